// File: rtl/instr_mem_loader_if.sv
// Instruction-word stream into the loader: valid/ready handshake with a last-word flag.
// master = word source (boot ROM, testbench), slave = loader.
interface instr_mem_loader_if #(
  parameter int WORD_LEN = 16
);
  logic                word_valid;
  logic [WORD_LEN-1:0] word_data;
  logic                word_last;
  logic                word_ready;

  modport master (output word_valid, output word_data, output word_last, input word_ready);
  modport slave  (input word_valid, input word_data, input word_last, output word_ready);
endinterface

// File: rtl/instr_mem_loader.sv
// Streams instruction words into the nibble-wide instruction memory, one cell per cycle,
// most-significant cell at the lowest address so the fetch side reads words back unchanged.
module instr_mem_loader #(
  parameter int WORD_LEN       = 16,
  parameter int MEM_CELL_SIZE  = 4,
  parameter int INSTR_MEM_SIZE = 256,
  parameter int ADDR_W         = $clog2(INSTR_MEM_SIZE),
  parameter int CELLS          = WORD_LEN / MEM_CELL_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  instr_mem_loader_if.slave        wr,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [MEM_CELL_SIZE-1:0] mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W-1:0]        words_written
);

  localparam int CIDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   PTR_STEP   = (ADDR_W + 1)'(CELLS);
  localparam logic [CIDX_W-1:0] CIDX_LAST  = CIDX_W'(CELLS - 1);
  localparam logic [CIDX_W-1:0] CIDX_ONE   = CIDX_W'(1);
  localparam logic [ADDR_W-1:0] WW_ONE     = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  // The extra top pointer bit flags a walk past the last cell instead of wrapping to 0.
  logic [ADDR_W:0]      ptr;
  logic [ADDR_W:0]      ptr_adv;
  logic [CIDX_W-1:0]    cell_idx;
  logic [WORD_LEN-1:0]  word_sh;
  logic                 last_q;
  logic                 arm;
  logic                 accept;
  logic                 cell_last;

  assign arm       = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign accept    = (state == S_ARMED) && wr.word_valid;
  assign cell_last = (state == S_WRITE) && (cell_idx == CIDX_LAST);
  assign ptr_adv   = ptr + PTR_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (wr.word_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (cell_last) begin
          if (last_q)                state_nxt = S_DONE;
          else if (ptr_adv[ADDR_W])  state_nxt = S_ERR;
          else                       state_nxt = S_ARMED;
        end
      end
      S_DONE: begin
        state_nxt = start ? S_ARMED : S_IDLE;
      end
      S_ERR: begin
        if (start) state_nxt = S_ARMED;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      cell_idx      <= '0;
      words_written <= '0;
    end else if (arm) begin
      ptr           <= {1'b0, base_addr & ALIGN_MASK};
      cell_idx      <= '0;
      words_written <= '0;
    end else if (state == S_WRITE) begin
      if (cell_last) begin
        ptr           <= ptr_adv;
        cell_idx      <= '0;
        words_written <= words_written + WW_ONE;
      end else begin
        cell_idx <= cell_idx + CIDX_ONE;
      end
    end
  end

  // Captured word shifts up one cell per write so the next cell is always on top.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_sh <= wr.word_data;
      last_q  <= wr.word_last;
    end else if (state == S_WRITE) begin
      word_sh <= word_sh << MEM_CELL_SIZE;
    end
  end

  always_comb begin
    wr.word_ready = 1'b0;
    mem_we        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    mem_addr      = ptr[ADDR_W-1:0] | {{(ADDR_W - CIDX_W){1'b0}}, cell_idx};
    mem_wdata     = word_sh[WORD_LEN-1 -: MEM_CELL_SIZE];
    case (state)
      S_ARMED: begin
        wr.word_ready = 1'b1;
        busy          = 1'b1;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a queue of expected cell writes (address, nibble, cycle)
// is built from each accepted word and checked against every DUT write; a memory image gives read-back.
module tb_instr_mem_loader;

  localparam int WORD_LEN = 16;
  localparam int CELL     = 4;
  localparam int MEMSZ    = 64;
  localparam int AW       = 6;
  localparam int CELLS    = WORD_LEN / CELL;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [CELL-1:0] mem_wdata;
  logic            busy;
  logic            done;
  logic            err;
  logic [AW-1:0]   words_written;

  instr_mem_loader_if #(.WORD_LEN(WORD_LEN)) wif ();

  instr_mem_loader #(
    .WORD_LEN(WORD_LEN),
    .MEM_CELL_SIZE(CELL),
    .INSTR_MEM_SIZE(MEMSZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .wr(wif),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .busy(busy),
    .done(done),
    .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  bit zero_wr = 1'b0;
  bit mon_on = 1'b0;
  logic [CELL-1:0] mem_img [MEMSZ];
  int exp_addr[$];
  int exp_data[$];
  int exp_cyc[$];
  int model_ptr = 0;
  int model_ww = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rd(input int a);
    return {mem_img[a], mem_img[a+1], mem_img[a+2], mem_img[a+3]};
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (mem_we === 1'b1) begin
        wr_cnt <= wr_cnt + 1;
        mem_img[mem_addr] <= mem_wdata;
        if (mem_addr == '0) zero_wr <= 1'b1;
        chk("ready_low_in_write", {31'd0, wif.word_ready}, 32'd0);
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0d data=%0h required no write", mem_addr, mem_wdata);
        end else begin
          chk("wr_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
          chk("wr_data", 32'(mem_wdata), 32'(exp_data.pop_front()));
          chk("wr_cycle", 32'(cyc), 32'(exp_cyc.pop_front()));
        end
      end
    end
  end

  task automatic start_at(input int a);
    base_addr = AW'(a);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_ptr = a & ~(CELLS - 1);
    model_ww = 0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    wif.word_valid = 1'b1;
    wif.word_data  = d;
    wif.word_last  = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wif.word_ready === 1'b1) begin
        @(posedge clk);
        #1;
        last_acc = cyc;
        for (int k = 0; k < CELLS; k++) begin
          exp_addr.push_back(model_ptr + k);
          exp_data.push_back(int'(d >> (WORD_LEN - CELL * (k + 1))) & 15);
          exp_cyc.push_back(last_acc + k);
        end
        model_ptr += CELLS;
        model_ww++;
        ok = 1'b1;
        break;
      end
    end
    chk("accept_seen", {31'd0, ok}, 32'd1);
    if (!ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_flag(input string name, input bit want_err);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((want_err ? err : done) === 1'b1) begin
        got = 1'b1;
        chk({name, "_latency"}, 32'(cyc), 32'(last_acc + CELLS));
        break;
      end
    end
    chk({name, "_seen"}, {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int d0, w0, a0, a1, a2;
    wif.word_valid = 1'b0;
    wif.word_data  = '0;
    wif.word_last  = 1'b0;

    // reset values
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, wif.word_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;

    // single word at 8
    start_at(8);
    @(negedge clk);
    chk("armed_busy", {31'd0, busy}, 32'd1);
    chk("armed_ready", {31'd0, wif.word_ready}, 32'd1);
    @(posedge clk);
    #1;
    d0 = done_cnt;
    send_word(16'h310A, 1'b1);
    wif.word_valid = 1'b0;
    wait_flag("done", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("single_done_once", 32'(done_cnt - d0), 32'd1);
    chk("single_words", 32'(words_written), 32'(model_ww));
    chk("single_words_lit", 32'(words_written), 32'd1);
    chk("single_readback", 32'(rd(8)), 32'h310A);
    chk("single_cell10", 32'(mem_img[10]), 32'h0);
    chk("single_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("single_idle_busy", {31'd0, busy}, 32'd0);

    // stream with valid held high
    start_at(8);
    w0 = wr_cnt;
    send_word(16'h310A, 1'b0);
    a0 = last_acc;
    send_word(16'h320B, 1'b0);
    a1 = last_acc;
    send_word(16'h3303, 1'b1);
    a2 = last_acc;
    wif.word_valid = 1'b0;
    wait_flag("done", 1'b0);
    chk("stream_spacing01", 32'(a1 - a0), 32'd5);
    chk("stream_spacing12", 32'(a2 - a1), 32'd5);
    chk("stream_write_count", 32'(wr_cnt - w0), 32'd12);
    chk("stream_words", 32'(words_written), 32'd3);
    chk("stream_rb8", 32'(rd(8)), 32'h310A);
    chk("stream_rb12", 32'(rd(12)), 32'h320B);
    chk("stream_rb16", 32'(rd(16)), 32'h3303);

    // misaligned base 0x0A aligns down to 8
    start_at(6'h0A);
    send_word(16'hBEEF, 1'b1);
    wif.word_valid = 1'b0;
    wait_flag("done", 1'b0);
    chk("misalign_rb8", 32'(rd(8)), 32'hBEEF);
    chk("misalign_rb12_untouched", 32'(rd(12)), 32'h320B);

    // overflow past the top of a 64-cell memory
    start_at(60);
    send_word(16'h1234, 1'b0);
    wif.word_data = 16'h5678;
    wif.word_last = 1'b0;
    wait_flag("err", 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("err_ready_low", {31'd0, wif.word_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("err_held", {31'd0, err}, 32'd1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    chk("err_rb60", 32'(rd(60)), 32'h1234);
    chk("err_no_cell0", {31'd0, zero_wr}, 32'd0);
    chk("err_words", 32'(words_written), 32'd1);
    chk("err_queue_empty", 32'(exp_addr.size()), 32'd0);
    wif.word_valid = 1'b0;
    start_at(8);
    @(negedge clk);
    chk("restart_err_clear", {31'd0, err}, 32'd0);
    chk("restart_ready", {31'd0, wif.word_ready}, 32'd1);
    chk("restart_words", 32'(words_written), 32'd0);
    @(posedge clk);
    #1;

    // reset during the cell-1 cycle of a word (loader already armed at 8)
    w0 = wr_cnt;
    send_word(16'hCAFE, 1'b1);
    wif.word_valid = 1'b0;
    @(posedge clk);
    #1;
    void'(exp_addr.pop_back());
    void'(exp_addr.pop_back());
    void'(exp_data.pop_back());
    void'(exp_data.pop_back());
    void'(exp_cyc.pop_back());
    void'(exp_cyc.pop_back());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_write_count", 32'(wr_cnt - w0), 32'd2);
    chk("rstmid_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("rstmid_cells", {16'd0, mem_img[8], mem_img[9], 8'd0}, 32'h0000CA00);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_ready", {31'd0, wif.word_ready}, 32'd0);
    chk("rstmid_words", 32'(words_written), 32'd0);
    start_at(16);
    send_word(16'h4321, 1'b1);
    wif.word_valid = 1'b0;
    wait_flag("done", 1'b0);
    chk("reload_rb16", 32'(rd(16)), 32'h4321);
    chk("reload_words", 32'(words_written), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart of the instruction memory: accepts 16-bit instruction words over a valid/ready stream and writes each one into the 4-bit-cell instruction memory.
- Each word is written as WORD_LEN/MEM_CELL_SIZE consecutive cells, most-significant nibble at the lowest address. This is the same cell order the fetch side concatenates, so a word written at address A reads back unchanged at PC=A.
- Sits between the testbench/boot source and the instruction memory write port; it replaces the hard-coded reset-time program.

Parameters:
- WORD_LEN, 16, instruction width in bits.
- MEM_CELL_SIZE, 4, width of one memory cell in bits.
- INSTR_MEM_SIZE, 256, number of cells; must be a power of two.
- ADDR_W, $clog2(INSTR_MEM_SIZE), cell address width.
- CELLS, WORD_LEN/MEM_CELL_SIZE (=4), cells per word.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  arm the loader at base_addr; one-cycle pulse.
- base_addr  in  ADDR_W  first cell address; low log2(CELLS) bits are forced to 0.
- word_valid  in  1  source has a word.
- word_data  in  WORD_LEN  instruction word.
- word_last  in  1  final word of the program; qualified by the handshake.
- word_ready  out  1  loader can accept a word.
- mem_we  out  1  cell write enable.
- mem_addr  out  ADDR_W  cell address.
- mem_wdata  out  MEM_CELL_SIZE  cell data.
- busy  out  1  state is not IDLE, DONE or ERR.
- done  out  1  one-cycle pulse after the last cell of the word flagged last.
- err  out  1  address overflow; held.
- words_written  out  ADDR_W  count of completed words since start.

Behaviour:
- States: IDLE, ARMED, WRITE, DONE, ERR.
- Reset: state=IDLE; pointer=0; cell index=0; all outputs 0. A reset mid-WRITE abandons the partial word; no further mem_we pulses occur.
- IDLE/DONE/ERR + start=1 -> ARMED:
  - pointer = {1'b0, base_addr aligned}, with an (ADDR_W+1)-bit pointer;
  - words_written=0; err cleared.
  - start in ARMED or WRITE is ignored.
- ARMED: word_ready=1.
  - On word_valid & word_ready: capture word_data and word_last into a shift register, go to WRITE.
  - Handshake occurs only when both signals are high in the same cycle; word_data is not required to be stable afterwards.
- WRITE: word_ready=0; mem_we=1 for exactly CELLS consecutive cycles.
  - Cycle k (0..CELLS-1): mem_addr = pointer+k; mem_wdata = word[WORD_LEN-1-k*MEM_CELL_SIZE -: MEM_CELL_SIZE].
  - After the cell k=CELLS-1 edge: pointer += CELLS; words_written++.
  - Then: if captured last -> DONE; else if pointer[ADDR_W]=1 (wrapped past INSTR_MEM_SIZE-1) -> ERR; else -> ARMED.
- Latency/throughput:
  - Word accepted at edge N; cells are written at edges N+1..N+CELLS.
  - word_ready is high again in the cycle after edge N+CELLS.
  - Maximum rate is 1 word per CELLS+1 cycles.
- DONE: done=1 for the single cycle of entry, then go to IDLE unless start is asserted.
- ERR: err=1 held; word_ready=0; mem_we=0. Exit only via start or rst.
- A last word that exactly fills the memory goes to DONE, not ERR.
- Writes never wrap to address 0.
- mem_addr and mem_wdata are don't-care when mem_we=0; the bench checks them only when mem_we=1.

Test Plan:
- Reset values: rst high 2 cycles -> word_ready=0, mem_we=0, busy=0, done=0, err=0, words_written=0.
- Single word: start, base_addr=8; word 0x310A with last=1 -> writes (8,3),(9,1),(10,0),(11,A) on consecutive edges; done pulses once; words_written=1; read-back at PC=8 gives 0x310A.
- Stream with backpressure: words 0x310A, 0x320B, 0x3303 (last on the third), word_valid held high throughout -> exactly 12 writes at cells 8..19, no duplicate accepts, word_ready low during each 4-cycle WRITE.
- Misaligned base: base_addr=0x0A -> first write at cell 8.
- Overflow (INSTR_MEM_SIZE=64): base_addr=60; words 0x1234 then 0x5678, last=0 on the first word -> cells 60..63 = 1,2,3,4; then err=1, word_ready=0; second word never accepted, no writes to cell 0. A following start clears err.
- Reset mid-WRITE: assert rst on the cell-1 cycle -> no mem_we pulse after that edge; state IDLE; a new start loads normally.
